// File: rtl/epp_host_pkg.sv
// rtl/epp_host_pkg.sv - shared command opcodes and FSM state encodings for the EPP host
package epp_host_pkg;

    localparam logic [1:0] OP_ADDR_WR = 2'b00;
    localparam logic [1:0] OP_ADDR_RD = 2'b01;
    localparam logic [1:0] OP_DATA_WR = 2'b10;
    localparam logic [1:0] OP_DATA_RD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer of parameterized width
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/epp_host.sv
// rtl/epp_host.sv - EPP bus host: one command per address/data strobe handshake
// Optional wait-edge timeout enabled by defining EPP_HOST_TIMEOUT_EN.
module epp_host
    import epp_host_pkg::*;
#(
    parameter int SETUP_CYC   = 2,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_timeout,
    output logic [7:0] db_o,
    output logic       db_oe,
    input  logic [7:0] db_i,
    output logic       astb_n,
    output logic       dstb_n,
    output logic       wr_n,
    input  logic       wait_i
);

    state_t     state, next_state;
    logic [1:0] op_q;
    logic [1:0] cur_op;
    logic [3:0] setup_cnt;
    logic       ready_q;
    logic       wait_s;
    logic       accept;
    logic       in_cycle;
    logic       timeout_hit;

    sync2 #(.WIDTH(1)) u_wait_sync (
        .clk (clk),
        .rst (rst),
        .d   (wait_i),
        .q   (wait_s)
    );

    assign accept = (state == ST_IDLE) && cmd_valid && ready_q;
    // Registered outputs are computed from next_state, so the op being accepted must be used directly.
    assign cur_op   = accept ? cmd_op : op_q;
    assign in_cycle = (next_state == ST_SETUP) || (next_state == ST_STROBE) ||
                      (next_state == ST_RELEASE);

`ifdef EPP_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] to_cnt;
    logic          to_q;

    assign timeout_hit = ((state == ST_STROBE) || (state == ST_RELEASE)) &&
                         (to_cnt == TW'(TIMEOUT_CYC - 1));
    assign rsp_timeout = to_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt <= '0;
            to_q   <= 1'b0;
        end else begin
            if ((state == ST_STROBE) || (state == ST_RELEASE))
                to_cnt <= to_cnt + 1'b1;
            else
                to_cnt <= '0;
            if (accept)
                to_q <= 1'b0;
            else if (timeout_hit)
                to_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = (TIMEOUT_CYC < 0);
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            op_q      <= OP_ADDR_WR;
            setup_cnt <= '0;
            ready_q   <= 1'b0;
            astb_n    <= 1'b1;
            dstb_n    <= 1'b1;
            wr_n      <= 1'b1;
            db_oe     <= 1'b0;
            db_o      <= '0;
            rsp_data  <= '0;
        end else begin
            state     <= next_state;
            ready_q   <= (next_state == ST_IDLE);
            setup_cnt <= (state == ST_SETUP && next_state == ST_SETUP) ? setup_cnt + 1'b1 : '0;
            astb_n    <= !((next_state == ST_STROBE) && !cur_op[1]);
            dstb_n    <= !((next_state == ST_STROBE) && cur_op[1]);
            wr_n      <= in_cycle ? cur_op[0] : 1'b1;
            db_oe     <= in_cycle ? ~cur_op[0] : 1'b0;
            if (accept) begin
                op_q     <= cmd_op;
                db_o     <= cmd_data;
                rsp_data <= '0;
            end
            if (state == ST_STROBE && wait_s && !timeout_hit && op_q[0])
                rsp_data <= db_i;
            if (timeout_hit)
                rsp_data <= '0;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (accept) next_state = ST_SETUP;
            ST_SETUP:   if (setup_cnt == 4'(SETUP_CYC - 1)) next_state = ST_STROBE;
            ST_STROBE: begin
                if (timeout_hit)      next_state = ST_RESP;
                else if (wait_s)      next_state = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (timeout_hit)      next_state = ST_RESP;
                else if (!wait_s)     next_state = ST_RESP;
            end
            ST_RESP:    next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = ready_q;
        rsp_valid = (state == ST_RESP);
    end

endmodule
